// File: rtl/regfile_cmd_master_if.sv
// Command/response channel bundle between a requester and regfile_cmd_master.
// The slave modport is the engine side; the master modport is the requester side.
interface regfile_cmd_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH/8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [BE_WIDTH-1:0]   cmd_be;
   logic [DATA_WIDTH-1:0] cmd_mask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_be, cmd_mask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_be, cmd_mask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/regfile_cmd_master.sv
// Single-outstanding read / write / read-modify-write engine driving one write
// port and one read port of a register file. Every output is decoded from the
// state and capture flops; the read address is parked whenever not reading so
// read-clear registers are never disturbed.
module regfile_cmd_master #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    BE_WIDTH   = DATA_WIDTH/8,
   parameter logic [ADDR_WIDTH-1:0] PARK_ADDR  = {ADDR_WIDTH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_cmd_master_if.slave   cif,
   output logic                  busy,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [BE_WIDTH-1:0]   wr_be,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RMW = 2'b10;

   state_t                state_q, state_d;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_WIDTH-1:0]   be_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   // State register; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Command capture on accept, read data capture at the end of the RD cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cif.cmd_valid) begin
               op_q    <= cif.cmd_op;
               addr_q  <= cif.cmd_addr;
               wdata_q <= cif.cmd_wdata;
               be_q    <= cif.cmd_be;
               mask_q  <= cif.cmd_mask;
               rdata_q <= '0;
               err_q   <= (cif.cmd_op == 2'b11);
            end
            RD:      rdata_q <= rd_data;
            default: ;
         endcase
      end
   end

   // Next-state and output decode from registered state only.
   always_comb begin
      state_d       = state_q;
      cif.cmd_ready = 1'b0;
      cif.rsp_valid = 1'b0;
      cif.rsp_rdata = '0;
      cif.rsp_err   = 1'b0;
      busy          = (state_q != IDLE);
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      wr_be         = '0;
      rd_addr       = PARK_ADDR;
      case (state_q)
         IDLE: begin
            cif.cmd_ready = 1'b1;
            if (cif.cmd_valid) begin
               case (cif.cmd_op)
                  OP_RD, OP_RMW: state_d = RD;
                  OP_WR:         state_d = WR;
                  default:       state_d = RSP;
               endcase
            end
         end
         RD: begin
            rd_addr = addr_q;
            state_d = (op_q == OP_RMW) ? WR : RSP;
         end
         WR: begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
            if (op_q == OP_RMW) begin
               wr_data = (rdata_q & ~mask_q) | (wdata_q & mask_q);
               wr_be   = '1;
            end else begin
               wr_data = wdata_q;
               wr_be   = be_q;
            end
            state_d = RSP;
         end
         RSP: begin
            cif.rsp_valid = 1'b1;
            cif.rsp_err   = err_q;
            if (op_q == OP_RD || op_q == OP_RMW) cif.rsp_rdata = rdata_q;
            if (cif.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/regfile_cmd_master.md
Name: regfile_cmd_master

Overview:
Initiator-side access engine for the generated multi-port register files. It drives one write port (wr_en/wr_addr/wr_data/wr_be) and one read port (rd_addr/rd_data) of a regfile instance. Commands arrive over a valid/ready channel; each one executes as a single read, write or read-modify-write, and the result returns on a valid/ready response channel. Only one command is outstanding at a time. When idle, the block parks the read address on an unmapped address so that read-clear registers are never cleared by accident.

Parameters:
ADDR_WIDTH, 8, regfile address width
DATA_WIDTH, 32, regfile data width; must be a multiple of 8
BE_WIDTH, DATA_WIDTH/8, byte-enable width
PARK_ADDR, 8'hFF, rd_addr value in every state except RD; must not map to any register

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_op  in  2  00 read, 01 write, 10 read-modify-write, 11 reserved
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_be  in  BE_WIDTH  byte enables, write op only
cmd_mask  in  DATA_WIDTH  bit mask, RMW op only
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_rdata  out  DATA_WIDTH  read data (read and RMW), 0 for write and error
rsp_err  out  1  reserved opcode
busy  out  1  state != IDLE
wr_en  out  1  regfile write enable
wr_addr  out  ADDR_WIDTH  regfile write address
wr_data  out  DATA_WIDTH  regfile write data
wr_be  out  BE_WIDTH  regfile byte enables
rd_addr  out  ADDR_WIDTH  regfile read address
rd_data  in  DATA_WIDTH  regfile read data, combinational from rd_addr

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset state: state=IDLE; all capture registers 0; wr_en=0; wr_addr=0; wr_data=0; wr_be=0; rd_addr=PARK_ADDR; rsp_valid=0; rsp_err=0; rsp_rdata=0; busy=0; cmd_ready=1.
- FSM states: IDLE, RD, WR, RSP. All outputs decode from state flops and capture flops only. No combinational path runs from any input to any output.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture op, addr, wdata, be and mask.
  - Op 00 goes to RD. Op 01 goes to WR. Op 10 goes to RD.
  - Op 11 goes to RSP with err=1 and rdata=0.
- RD (exactly 1 cycle):
  - rd_addr=captured addr. Sample rd_data into rdata_q at the end of the cycle.
  - Op 00 then goes to RSP. Op 10 then goes to WR.
- WR (exactly 1 cycle):
  - wr_en=1, wr_addr=captured addr.
  - Write op: wr_data=wdata, wr_be=be.
  - RMW op: wr_data=(rdata_q & ~mask) | (wdata & mask), wr_be all ones.
  - Then go to RSP.
  - Outside WR: wr_en=0, and wr_addr/wr_data/wr_be are driven to 0.
- RSP:
  - rsp_valid=1. rsp_rdata = rdata_q for read and RMW, 0 for write. rsp_err as captured.
  - All response fields are held stable until rsp_ready=1. The response completes on the first rsp_ready=1 cycle and the FSM returns to IDLE the next cycle.
- rd_addr=PARK_ADDR in IDLE, WR and RSP. The parked address is never sampled.
- Latency from the accept edge T to rsp_valid:
  - read: T+2
  - write: T+2 (WR cycle at T+1)
  - RMW: T+3 (RD at T+1, WR at T+2)
  - reserved op: T+1
- Throughput: cmd_ready is low from the accept edge until the cycle after the response handshake. This gives a minimum of 3 cycles per read or write command when rsp_ready is held high.
- Simultaneous cmd_valid with a pending response: the command is not accepted and is held by the sender (valid must stay asserted with stable payload until ready).
- cmd_be=0 on a write still produces a 1-cycle wr_en pulse with wr_be=0.
- Address wrap: no increment logic. Addresses 0 and 2^ADDR_WIDTH-1 pass through unchanged.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - A pending wr_en pulse is dropped and the response is discarded.
  - rd_addr returns to PARK_ADDR asynchronously.

Test Plan:
- Reset, then write op: addr=0x04, wdata=0xDEADBEEF, be=4'b0101 -> wr_en high for exactly 1 cycle at T+1 with wr_addr=0x04 and wr_be=0101; rsp_valid at T+2 with rdata=0, err=0.
- Read op: addr=0x10, regfile model returns 0x12345678 -> rd_addr=0x10 only at T+1 and PARK_ADDR on every other cycle; rsp_rdata=0x12345678 at T+2.
- RMW op: addr=0x08, old=0xFFFF0000, wdata=0x0000AAAA, mask=0x0000FFFF -> wr_data=0xFFFFAAAA, wr_be=4'hF at T+2; rsp_rdata=0xFFFF0000 at T+3.
- Reserved op 11 -> no wr_en pulse, rd_addr never leaves PARK_ADDR; rsp_valid at T+1 with err=1, rdata=0.
- Response backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid stays high -> rsp fields stable and cmd_ready=0 throughout; the second command is accepted the cycle after the handshake.
- Reset asserted during the WR cycle of an RMW -> wr_en=0 immediately, rsp_valid never asserts, cmd_ready=1 after release.
